mmio_responder: RTL and testbench

//  Consumes the packed PSL MMIO request bus inside sv_afu and produces the packed MMIO reply bus.

---
 rtl/mmio_responder.sv | 125 ++++++++++++
 tb/tb_mmio_responder.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mmio_responder.sv
// PSL MMIO slave: AFU descriptor (config) reads plus a small problem-state register file.
// One request in flight, acked two cycles after mmval, odd parity on every returned word.
module mmio_responder #(
  parameter int unsigned NUM_REGS = 4,
  parameter logic [15:0] REQ_PROG = 16'h8010
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   parity_enabled,
  input  logic [93:0]            mmio_in,
  output logic [65:0]            mmio_out,
  output logic [0:NUM_REGS*64-1] regs_out,
  output logic                   parity_error
);
  localparam int unsigned DW = 64;
  localparam int unsigned HW = 32;
  localparam int unsigned AW = 24;
  localparam int unsigned IW = AW - 1;
  localparam logic [DW-1:0] CFG_DW0 = {16'd0, 16'd1, 16'd0, REQ_PROG};

  typedef enum logic [1:0] {S_IDLE, S_DECODE, S_ACK} state_t;

  logic          w_val, w_cfg, w_rnw, w_dw, w_adpar, w_unused_datapar;
  logic [AW-1:0] w_ad;
  logic [DW-1:0] w_wdata;

  // Request bus unpack; incoming data parity is deliberately not checked.
  assign {w_val, w_cfg, w_rnw, w_dw, w_ad, w_adpar, w_wdata, w_unused_datapar} = mmio_in;

  state_t        r_state;
  logic          r_cfg, r_rnw, r_dw, r_bad;
  logic [AW-1:0] r_ad;
  logic [DW-1:0] r_wdata;
  logic          r_ack, r_rpar, r_perr;
  logic [DW-1:0] r_rdata;
  logic [DW-1:0] r_regs [NUM_REGS];

  logic [IW-1:0] w_idx;
  logic          w_lo;
  logic [DW-1:0] w_dword, w_rdata;
  logic [HW-1:0] w_word;

  assign w_idx = r_ad[AW-1:1];
  assign w_lo  = r_ad[0];

  // Addressed dword: descriptor dword 0 in config space, register file otherwise, zero if unmapped.
  always_comb begin
    w_dword = '0;
    if (r_cfg) begin
      if (w_idx == '0) w_dword = CFG_DW0;
    end else begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (w_idx == IW'(i)) w_dword = r_regs[i];
      end
    end
  end

  assign w_word  = w_lo ? w_dword[HW-1:0] : w_dword[DW-1:HW];
  assign w_rdata = r_bad ? '1 : (r_dw ? w_dword : {w_word, w_word});

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cfg   <= 1'b0;
      r_rnw   <= 1'b0;
      r_dw    <= 1'b0;
      r_bad   <= 1'b0;
      r_ad    <= '0;
      r_wdata <= '0;
      r_ack   <= 1'b0;
      r_rdata <= '0;
      r_rpar  <= 1'b1;
      r_perr  <= 1'b0;
      for (int unsigned i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_val) begin
            r_cfg   <= w_cfg;
            r_rnw   <= w_rnw;
            r_dw    <= w_dw;
            r_ad    <= w_ad;
            r_wdata <= w_wdata;
            r_bad   <= parity_enabled & ~(^{w_ad, w_adpar});
            r_state <= S_DECODE;
          end
        end
        S_DECODE: begin
          r_state <= S_ACK;
          r_ack   <= 1'b1;
          if (r_rnw) begin
            r_rdata <= w_rdata;
            r_rpar  <= ~^w_rdata;
          end
          // A bad address parity blocks the write but the access is still acked.
          if (r_bad) begin
            r_perr <= 1'b1;
          end else if (!r_rnw && !r_cfg) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
              if (w_idx == IW'(i)) begin
                if (r_dw)      r_regs[i]          <= r_wdata;
                else if (w_lo) r_regs[i][HW-1:0]  <= r_wdata[HW-1:0];
                else           r_regs[i][DW-1:HW] <= r_wdata[HW-1:0];
              end
            end
          end
        end
        S_ACK: begin
          r_state <= S_IDLE;
          r_ack   <= 1'b0;
          r_rdata <= '0;
          r_rpar  <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign mmio_out     = {r_ack, r_rdata, r_rpar};
  assign parity_error = r_perr;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs
    assign regs_out[g*DW +: DW] = r_regs[g];
  end
endmodule

// File: tb/tb_mmio_responder.sv
// Bench for mmio_responder: transaction-level model compared every cycle, plus directed literal pins.
module tb_mmio_responder;
  localparam int unsigned NUM_REGS = 4;
  localparam logic [63:0] CFG0 = 64'h0000_0001_0000_8010;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic parity_enabled = 1'b0;
  logic [93:0] mmio_in;
  logic [65:0] mmio_out;
  logic [0:NUM_REGS*64-1] regs_out;
  logic parity_error;

  logic        v_val = 1'b0, v_cfg = 1'b0, v_rnw = 1'b0, v_dw = 1'b0, v_adpar = 1'b0, v_dpar = 1'b0;
  logic [23:0] v_ad = '0;
  logic [63:0] v_data = '0;

  assign mmio_in = {v_val, v_cfg, v_rnw, v_dw, v_ad, v_adpar, v_data, v_dpar};

  mmio_responder #(.NUM_REGS(NUM_REGS), .REQ_PROG(16'h8010)) dut (
    .clock(clock), .reset(reset), .parity_enabled(parity_enabled),
    .mmio_in(mmio_in), .mmio_out(mmio_out), .regs_out(regs_out), .parity_error(parity_error)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  // Model: the whole transaction is resolved at capture and becomes visible one edge later.
  logic [63:0] m_regs [NUM_REGS];
  logic [63:0] p_regs [NUM_REGS];
  logic        m_perr, m_ack, p_perr, m_valid = 1'b0;
  logic [63:0] m_data, p_data;
  bit          pend = 1'b0;
  int          pend_edge = 0, next_free = 0;

  logic [65:0] obs_out;
  logic [0:NUM_REGS*64-1] obs_regs;
  logic        obs_perr;

  task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %h expected %h", name, edge_n, act, exp);
    end
  endtask

  task automatic do_txn();
    logic [22:0] idx;
    logic [63:0] val;
    logic [31:0] w;
    logic        bad, hit;
    idx = v_ad[23:1];
    hit = (32'(idx) < NUM_REGS);
    for (int i = 0; i < NUM_REGS; i++) p_regs[i] = m_regs[i];
    p_perr = m_perr;
    p_data = '0;
    bad = parity_enabled && ((^{v_ad, v_adpar}) == 1'b0);
    if (bad) begin
      p_perr = 1'b1;
      if (v_rnw) p_data = '1;
    end else if (v_rnw) begin
      if (v_cfg) val = (idx == 23'd0) ? CFG0 : 64'd0;
      else       val = hit ? m_regs[v_ad[2:1]] : 64'd0;
      w = v_ad[0] ? val[31:0] : val[63:32];
      p_data = v_dw ? val : {w, w};
    end else if (!v_cfg && hit) begin
      if (v_dw)         p_regs[v_ad[2:1]]        = v_data;
      else if (v_ad[0]) p_regs[v_ad[2:1]][31:0]  = v_data[31:0];
      else              p_regs[v_ad[2:1]][63:32] = v_data[31:0];
    end
  endtask

  task automatic model_step();
    edge_n++;
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) m_regs[i] = '0;
      m_perr = 1'b0; m_ack = 1'b0; m_data = '0;
      pend = 1'b0; next_free = edge_n + 1; m_valid = 1'b1;
    end else begin
      m_ack = 1'b0; m_data = '0;
      if (pend && pend_edge == edge_n) begin
        for (int i = 0; i < NUM_REGS; i++) m_regs[i] = p_regs[i];
        m_perr = p_perr; m_ack = 1'b1; m_data = p_data; pend = 1'b0;
      end
      if (v_val && edge_n >= next_free) begin
        do_txn();
        pend = 1'b1; pend_edge = edge_n + 1; next_free = edge_n + 3;
      end
    end
  endtask

  task automatic compare_all();
    logic par;
    if (!m_valid) return;
    par = ($countones(m_data) % 2 == 0);
    check("ack",  66'(mmio_out[65]), 66'(m_ack));
    check("data", 66'(mmio_out[64:1]), 66'(m_data));
    check("dpar", 66'(mmio_out[0]), 66'(par));
    check("perr", 66'(parity_error), 66'(m_perr));
    for (int i = 0; i < NUM_REGS; i++) check($sformatf("reg%0d", i), 66'(regs_out[i*64 +: 64]), 66'(m_regs[i]));
  endtask

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
    compare_all();
  endtask

  // One request held for a single cycle; observation taken on the ack cycle.
  task automatic issue(input logic cfg, input logic rnw, input logic dw, input logic [23:0] ad,
                       input logic [63:0] data, input logic good_par);
    v_val = 1'b1; v_cfg = cfg; v_rnw = rnw; v_dw = dw; v_ad = ad; v_data = data;
    v_adpar = good_par ? ~^ad : ^ad;
    tick();
    v_val = 1'b0;
    tick();
    obs_out = mmio_out; obs_regs = regs_out; obs_perr = parity_error;
    tick();
  endtask

  initial begin
    logic [7:0] ack_mask;
    tick(); tick();
    check("rst_out",  mmio_out, {1'b0, 64'd0, 1'b1});
    check("rst_regs", 66'(regs_out == '0), 66'(1));
    check("rst_perr", 66'(parity_error), 66'(0));
    reset = 1'b0;
    tick();

    issue(1'b1, 1'b1, 1'b1, 24'd0, 64'd0, 1'b1);
    check("t1_cfg_read", obs_out, {1'b1, CFG0, 1'b0});

    issue(1'b0, 1'b0, 1'b1, 24'd2, 64'hDEAD_BEEF_0123_4567, 1'b1);
    check("t2_write_ack", obs_out, {1'b1, 64'd0, 1'b1});
    check("t2_reg1", 66'(obs_regs[64:127]), 66'(64'hDEAD_BEEF_0123_4567));
    issue(1'b0, 1'b1, 1'b1, 24'd2, 64'd0, 1'b1);
    check("t2_read", obs_out, {1'b1, 64'hDEAD_BEEF_0123_4567, 1'b1});

    issue(1'b0, 1'b0, 1'b0, 24'd3, 64'h0000_0000_CAFE_F00D, 1'b1);
    check("t3_reg1", 66'(obs_regs[64:127]), 66'(64'hDEAD_BEEF_CAFE_F00D));
    issue(1'b0, 1'b1, 1'b0, 24'd2, 64'd0, 1'b1);
    check("t3_word_read", obs_out, {1'b1, 64'hDEAD_BEEF_DEAD_BEEF, 1'b1});

    parity_enabled = 1'b1;
    issue(1'b0, 1'b0, 1'b1, 24'd0, 64'h1111_2222_3333_4444, 1'b0);
    check("t4_ack", 66'(obs_out[65]), 66'(1));
    check("t4_reg0", 66'(obs_regs[0:63]), 66'(0));
    check("t4_perr", 66'(obs_perr), 66'(1));
    issue(1'b0, 1'b1, 1'b1, 24'd0, 64'd0, 1'b0);
    check("t4_bad_read", obs_out, {1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1});
    check("t4_sticky", 66'(obs_perr), 66'(1));

    ack_mask = '0;
    v_cfg = 1'b0; v_rnw = 1'b1; v_dw = 1'b1; v_ad = 24'(2 * NUM_REGS); v_adpar = ~^v_ad;
    for (int k = 0; k < 8; k++) begin
      v_val = (k < 4);
      tick();
      ack_mask[k] = mmio_out[65];
      if (mmio_out[65]) check("t5_unmapped", 66'(mmio_out[64:1]), 66'(0));
    end
    check("t5_ack_pattern", 66'(ack_mask), 66'(8'b0001_0010));

    for (int n = 0; n < 3000; n++) begin
      reset          = ($urandom_range(199) == 0);
      if ($urandom_range(15) == 0) parity_enabled = $urandom_range(1);
      v_val   = $urandom_range(1);
      v_cfg   = ($urandom_range(4) == 0);
      v_rnw   = $urandom_range(1);
      v_dw    = $urandom_range(1);
      v_ad    = 24'($urandom_range(11));
      if (v_dw) v_ad[0] = 1'b0;
      v_adpar = ($urandom_range(9) == 0) ? ^v_ad : ~^v_ad;
      v_data  = {$urandom, $urandom};
      v_dpar  = $urandom_range(1);
      tick();
    end
    reset = 1'b0; v_val = 1'b0;
    tick(); tick(); tick();

    v_val = 1'b1; v_cfg = 1'b0; v_rnw = 1'b0; v_dw = 1'b1; v_ad = 24'd4; v_adpar = ~^v_ad;
    v_data = 64'h0F0F_1234_5678_9ABC;
    tick();
    v_val = 1'b0; reset = 1'b1;
    tick();
    check("t6_no_ack", 66'(mmio_out[65]), 66'(0));
    check("t6_regs_clear", 66'(regs_out == '0), 66'(1));
    reset = 1'b0;
    tick();
    check("t6_still_clear", 66'(regs_out == '0), 66'(1));
    v_val = 1'b1; v_rnw = 1'b1; v_ad = 24'd4; v_adpar = ~^v_ad;
    tick();
    v_val = 1'b0;
    tick();
    check("t6_new_ack", mmio_out, {1'b1, 64'd0, 1'b1});
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
